// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO divide unit: FSM encodings and common constants.
package hilo_div_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DIVZERO = 2'b01,
    S_DIVON   = 2'b10,
    S_DONE    = 2'b11
  } div_state_e;

  localparam int          DIV_CYCLES = 32;
  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam logic        DivStart   = 1'b1;
  localparam logic        DivStop    = 1'b0;

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division iteration: shift the working register left, then try
// to subtract the divisor magnitude from its upper DATA_W+1 bits.
module hilo_div_unit_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] work,
  input  logic [DATA_W-1:0] divisor,
  output logic [2*DATA_W:0] next_work
);

  logic [2*DATA_W:0] shifted_s;
  logic [DATA_W+1:0] diff_s;

  assign shifted_s = {work[2*DATA_W-1:0], 1'b0};
  // One extra bit on the subtraction so its MSB is the borrow (negative result).
  assign diff_s    = {1'b0, shifted_s[2*DATA_W:DATA_W]} - {2'b00, divisor};

  // Keep the difference and set the quotient bit, or restore the shifted value.
  always_comb begin
    next_work = shifted_s;
    if (diff_s[DATA_W+1] == 1'b0) begin
      next_work = {diff_s[DATA_W:0], shifted_s[DATA_W-1:1], 1'b1};
    end else begin
      next_work = shifted_s;
    end
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Sequential MIPS DIV/DIVU engine producing HI (remainder) and LO (quotient).
// Optional feature macro: DIV_ANNUL_EN adds annul_i to cancel an in-flight divide.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              signed_div_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
`ifdef DIV_ANNUL_EN
  input  logic              annul_i,
`endif
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W);
  localparam logic [DATA_W-1:0] ZERO_W   = DATA_W'(ZeroWord);

  div_state_e          state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [2*DATA_W:0]   work_r, work_s, step_s;
  logic                neg_quot_r, neg_quot_s;
  logic                neg_rem_r, neg_rem_s;
  logic [DATA_W-1:0]   hi_r, hi_s, lo_r, lo_s;
  logic                ready_r, ready_s;
  logic                annul_s;
  logic [DATA_W-1:0]   op1_mag_s, op2_mag_s, divisor_mag_r, divisor_mag_s;
  logic [DATA_W-1:0]   quot_s, rem_s;
  logic                unused_s;

`ifdef DIV_ANNUL_EN
  assign annul_s = annul_i;
`else
  assign annul_s = 1'b0;
`endif

  assign op1_mag_s = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign op2_mag_s = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign quot_s    = work_r[DATA_W-1:0];
  assign rem_s     = work_r[2*DATA_W-1:DATA_W];
  // The register MSB is always clear once a step settles; it only matters inside a step.
  assign unused_s  = work_r[2*DATA_W];

  hilo_div_unit_div_step #(.DATA_W(DATA_W)) u_div_step (
    .work      (work_r),
    .divisor   (divisor_mag_r),
    .next_work (step_s)
  );

  // Next-state and datapath update for the divide FSM.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    work_s        = work_r;
    divisor_mag_s = divisor_mag_r;
    neg_quot_s    = neg_quot_r;
    neg_rem_s     = neg_rem_r;
    hi_s          = hi_r;
    lo_s          = lo_r;
    if (annul_s) begin
      state_s = S_IDLE;
      cnt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_i == DivStart) begin
            cnt_s         = {CNT_W{1'b0}};
            divisor_mag_s = op2_mag_s;
            neg_quot_s    = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_s     = signed_div_i & opdata1_i[DATA_W-1];
            if (opdata2_i == ZERO_W) begin
              // Divide-by-zero keeps the raw dividend for HI.
              state_s = S_DIVZERO;
              work_s  = {{(DATA_W+1){1'b0}}, opdata1_i};
            end else begin
              state_s = S_DIVON;
              work_s  = {{(DATA_W+1){1'b0}}, op1_mag_s};
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_DIVZERO: begin
          state_s = S_DONE;
          lo_s    = {DATA_W{1'b1}};
          hi_s    = work_r[DATA_W-1:0];
        end
        S_DIVON: begin
          if (cnt_r == LAST_CNT) begin
            state_s = S_DONE;
            lo_s    = neg_quot_r ? -quot_s : quot_s;
            hi_s    = neg_rem_r  ? -rem_s  : rem_s;
          end else begin
            work_s = step_s;
            cnt_s  = cnt_r + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (start_i == DivStop) begin
            state_s = S_IDLE;
          end else begin
            state_s = S_DONE;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
    ready_s = (state_s == S_DONE);
  end

  // State and result registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      work_r        <= {(2*DATA_W+1){1'b0}};
      divisor_mag_r <= ZERO_W;
      neg_quot_r    <= 1'b0;
      neg_rem_r     <= 1'b0;
      hi_r          <= ZERO_W;
      lo_r          <= ZERO_W;
      ready_r       <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      work_r        <= work_s;
      divisor_mag_r <= divisor_mag_s;
      neg_quot_r    <= neg_quot_s;
      neg_rem_r     <= neg_rem_s;
      hi_r          <= hi_s;
      lo_r          <= lo_s;
      ready_r       <= ready_s;
    end
  end

  assign busy_o  = (state_r == S_DIVON) | (state_r == S_DIVZERO) |
                   ((state_r == S_IDLE) & start_i);
  assign ready_o = ready_r;
  assign hi_o    = hi_r;
  assign lo_o    = lo_r;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: expected {hi,lo} queued at issue, checked on ready rise.
module tb_hilo_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_div;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;
  logic        ready_prev = 1'b0;

  hilo_div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
`ifdef DIV_ANNUL_EN
    .annul_i      (annul),
`endif
    .busy_o       (busy),
    .ready_o      (ready),
    .hi_o         (hi),
    .lo_o         (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rising ready pops one expected result.
  always @(negedge clk) begin
    if (ready === 1'b1 && ready_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got ready=1 expected no pending result");
      end else begin
        mon_exp = exp_q.pop_front();
        check("mon_hi", hi, mon_exp[63:32]);
        check("mon_lo", lo, mon_exp[31:0]);
      end
    end
    ready_prev <= ready;
  end

  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int exp_lat, input int hold);
    int  n;
    int  bcnt;
    bit  got;
    exp_q.push_back({eh, el});
    @(negedge clk);
    start = 1'b1; signed_div = s; op1 = a; op2 = b;
    #1 check("busy_accept", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 op1 = 32'hDEAD_BEEF; op2 = 32'h0000_0000; signed_div = ~s;
    n = 0; bcnt = 0; got = 1'b0;
    while (!got && n < 80) begin
      @(negedge clk);
      if (ready === 1'b1) got = 1'b1;
      else begin
        n++;
        if (busy === 1'b1) bcnt++;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready after %0d cycles expected %0d", n, exp_lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check("latency", n, exp_lat);
      check("busy_cycles", bcnt, exp_lat);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_ready", {31'd0, ready}, 32'd1);
      check("hold_hi", hi, eh);
      check("hold_lo", lo, el);
    end
    start = 1'b0;
    @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd0);
    check("keep_hi", hi, eh);
    check("keep_lo", lo, el);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; signed_div = 1'b0; op1 = 32'd0; op2 = 32'd0; annul = 1'b0;
    #3;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk) reset = 1'b1;

    do_div(1'b0, 32'd100,        32'd7,        32'd2,        32'd14,       33, 0);
    do_div(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    do_div(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,       32'h8000_0000, 33, 0);
    do_div(1'b0, 32'd5,          32'd0,        32'd5,        32'hFFFF_FFFF, 1, 0);
    do_div(1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1, 0);
    do_div(1'b1, 32'd7,          32'hFFFF_FFFE, 32'd1,       32'hFFFF_FFFD, 33, 0);
    do_div(1'b0, 32'h8000_0000,  32'd3,        32'd2,        32'h2AAA_AAAA, 33, 0);
    do_div(1'b0, 32'd7,          32'd9,        32'd7,        32'd0,        33, 3);
    do_div(1'b0, 32'hFFFF_FFFF,  32'd1,        32'd0,        32'hFFFF_FFFF, 33, 0);

    // Reset in the middle of 1000/3: no partial result may appear.
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0; start = 1'b0;
    #1;
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_ready", {31'd0, ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("postrst_ready", {31'd0, ready}, 32'd0);
      check("postrst_busy", {31'd0, busy}, 32'd0);
    end

`ifdef DIV_ANNUL_EN
    do_div(1'b0, 32'd20, 32'd6, 32'd2, 32'd3, 33, 0);
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    check("annul_busy", {31'd0, busy}, 32'd0);
    repeat (40) begin
      @(negedge clk);
      check("annul_ready", {31'd0, ready}, 32'd0);
    end
    check("annul_hi", hi, 32'd2);
    check("annul_lo", lo, 32'd3);
    do_div(1'b0, 32'd9, 32'd4, 32'd1, 32'd2, 33, 0);
`endif

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
